seg7_scan_reader: RTL

SEG7_SCAN_READER -- requirements
Module: seg7_scan_reader

---
 rtl/seg7_scan_reader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_reader.sv
// Recovers the digits shown on a multiplexed, active-low 7-segment display by
// sampling its segment and anode lines once they have been steady for a while.
module seg7_scan_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic [3:0] an_in,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] valid,
    output logic       err,
    output logic       frame_done,
    output logic       stale
);

    typedef enum logic {SETTLE, HELD} state_t;

    localparam logic [7:0]  STAB_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0]  STAB_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [23:0] TO_LAST   = 24'(TIMEOUT - 1);

    logic [10:0]      r_s1;
    logic [10:0]      r_s2;
    logic [10:0]      r_prev;
    logic [7:0]       r_stab;
    logic [23:0]      r_tcnt;
    logic [3:0]       r_cov;
    logic [3:0]       r_valid;
    logic [3:0][3:0]  r_digits;
    logic             r_err;
    logic             r_frameDone;
    logic             r_stale;
    state_t           r_state;
    state_t           w_next;

    logic             w_same;
    logic             w_capture;
    logic [3:0]       w_an;
    logic [6:0]       w_seg;
    logic [1:0]       w_pos;
    logic             w_posOk;
    logic [3:0]       w_val;
    logic             w_segOk;
    logic             w_legal;
    logic             w_bad;
    logic [3:0]       w_covNext;

    assign w_same = (r_s2 == r_prev);
    assign w_an   = r_s2[10:7];
    assign w_seg  = r_s2[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= {an_in, seg_in};
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stab <= '0;
        end else if (!w_same) begin
            r_stab <= '0;
        end else if (r_stab != STAB_MAX) begin
            r_stab <= r_stab + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SETTLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SETTLE: if (w_same && r_stab == STAB_LAST) w_next = HELD;
            HELD:   if (!w_same) w_next = SETTLE;
            default: w_next = SETTLE;
        endcase
    end

    // The capture fires on the single edge where the count reaches its limit.
    always_comb begin
        w_capture = (r_state == SETTLE) && w_same && (r_stab == STAB_LAST);
    end

    always_comb begin
        w_pos   = 2'd0;
        w_posOk = 1'b1;
        case (w_an)
            4'b1110: w_pos = 2'd0;
            4'b1101: w_pos = 2'd1;
            4'b1011: w_pos = 2'd2;
            4'b0111: w_pos = 2'd3;
            default: w_posOk = 1'b0;
        endcase
    end

    always_comb begin
        w_val   = 4'd0;
        w_segOk = 1'b1;
        case (w_seg)
            7'b0000001: w_val = 4'd0;
            7'b1001111: w_val = 4'd1;
            7'b0010010: w_val = 4'd2;
            7'b0000110: w_val = 4'd3;
            7'b1001100: w_val = 4'd4;
            7'b0100100: w_val = 4'd5;
            7'b0100000: w_val = 4'd6;
            7'b0001111: w_val = 4'd7;
            7'b0000000: w_val = 4'd8;
            7'b0000100: w_val = 4'd9;
            7'b0001000: w_val = 4'd10;
            7'b1111111: w_val = 4'd15;
            default:    w_segOk = 1'b0;
        endcase
    end

    assign w_legal   = w_capture && w_posOk && w_segOk;
    assign w_bad     = w_capture && w_posOk && !w_segOk;
    assign w_covNext = r_cov | (4'b0001 << w_pos);

    // A capture on the expiry edge wins, so stale is only considered otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits    <= '0;
            r_valid     <= '0;
            r_cov       <= '0;
            r_tcnt      <= '0;
            r_err       <= 1'b0;
            r_frameDone <= 1'b0;
            r_stale     <= 1'b0;
        end else begin
            r_err       <= w_bad;
            r_frameDone <= 1'b0;
            r_stale     <= 1'b0;
            if (w_legal) begin
                r_digits[w_pos] <= w_val;
                r_valid[w_pos]  <= 1'b1;
                r_tcnt          <= '0;
                if (w_covNext == 4'b1111) begin
                    r_frameDone <= 1'b1;
                    r_cov       <= '0;
                end else begin
                    r_cov <= w_covNext;
                end
            end else if (w_bad) begin
                r_valid[w_pos] <= 1'b0;
                r_tcnt         <= '0;
            end else if (r_tcnt == TO_LAST) begin
                r_stale <= 1'b1;
                r_valid <= '0;
                r_cov   <= '0;
                r_tcnt  <= '0;
            end else begin
                r_tcnt <= r_tcnt + 24'd1;
            end
        end
    end

    assign digit0     = r_digits[0];
    assign digit1     = r_digits[1];
    assign digit2     = r_digits[2];
    assign digit3     = r_digits[3];
    assign valid      = r_valid;
    assign err        = r_err;
    assign frame_done = r_frameDone;
    assign stale      = r_stale;

endmodule
